// File: rtl/m_dmux16_router.sv
// m_dmux16_router: 1-to-2 demultiplexing router with a one-word holding register per channel.
//
// An upstream word (i_data, i_valid / o_ready) is steered by i_sel to channel A (0) or B (1).
// Each channel is a single-entry buffer with an EMPTY/FULL state. A channel can accept a new
// word in the same cycle it hands its current word downstream, so a channel whose downstream is
// always ready sustains one word per cycle. The two channels drain independently of each other.
//
// Ports:
//   i_clk                  clock, all state updates on its rising edge
//   i_rst                  synchronous active-high reset
//   i_data [WIDTH-1:0]     upstream word
//   i_sel                  destination select, 0 = A, 1 = B
//   i_valid                upstream word valid
//   o_ready                offered word can be accepted (does not depend on i_valid)
//   o_a, o_b               held word per channel (keeps the last loaded value while EMPTY)
//   o_a_valid, o_b_valid   channel FULL
//   i_a_ready, i_b_ready   downstream ready per channel
//   o_a_count, o_b_count   completed downstream transfers per channel (mod 256)
//
// Build option: define DMUX16_ROUTER_COUNT_EN to include the transfer counters. Without it the
// counters are left out and both count outputs are tied to zero.

module m_dmux16_router #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_sel,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_a_valid,
    output logic             o_b_valid,
    input  logic             i_a_ready,
    input  logic             i_b_ready,
    output logic [7:0]       o_a_count,
    output logic [7:0]       o_b_count
);

    localparam logic StEmpty = 1'b0;
    localparam logic StFull  = 1'b1;

    logic             a_state_q, a_state_d;
    logic             b_state_q, b_state_d;
    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;

    logic a_can_load, b_can_load;
    logic a_load, b_load;
    logic a_drain, b_drain;

    // A channel can take a word if it is empty or is emptying this very cycle.
    always_comb begin
        a_can_load = (a_state_q == StEmpty) || i_a_ready;
        b_can_load = (b_state_q == StEmpty) || i_b_ready;
        o_ready    = i_sel ? b_can_load : a_can_load;

        a_load  = i_valid && a_can_load && !i_sel;
        b_load  = i_valid && b_can_load && i_sel;
        a_drain = (a_state_q == StFull) && i_a_ready;
        b_drain = (b_state_q == StFull) && i_b_ready;
    end

    always_comb begin
        a_state_d = a_state_q;
        a_data_d  = a_data_q;
        if (a_load) begin
            a_state_d = StFull;
            a_data_d  = i_data;
        end else if (a_drain) begin
            a_state_d = StEmpty;
        end

        b_state_d = b_state_q;
        b_data_d  = b_data_q;
        if (b_load) begin
            b_state_d = StFull;
            b_data_d  = i_data;
        end else if (b_drain) begin
            b_state_d = StEmpty;
        end
    end

    // Reset has priority: no load and no transfer completes on a reset edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_state_q <= StEmpty;
            b_state_q <= StEmpty;
            a_data_q  <= '0;
            b_data_q  <= '0;
        end else begin
            a_state_q <= a_state_d;
            b_state_q <= b_state_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
        end
    end

    assign o_a       = a_data_q;
    assign o_b       = b_data_q;
    assign o_a_valid = (a_state_q == StFull);
    assign o_b_valid = (b_state_q == StFull);

`ifdef DMUX16_ROUTER_COUNT_EN
    logic [7:0] a_count_q, a_count_d;
    logic [7:0] b_count_q, b_count_d;

    // 8-bit counters wrap 255 -> 0 naturally.
    always_comb begin
        a_count_d = a_drain ? a_count_q + 8'd1 : a_count_q;
        b_count_d = b_drain ? b_count_q + 8'd1 : b_count_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign o_a_count = a_count_q;
    assign o_b_count = b_count_q;
`else
    assign o_a_count = 8'd0;
    assign o_b_count = 8'd0;
`endif

endmodule

// File: doc/m_dmux16_router.md
M_DMUX16_ROUTER -- requirements
Module: m_dmux16_router

Interface
REQ-001 Parameter: WIDTH, 16, data word width in bits; all data ports SHALL use WIDTH.
REQ-002 Port: i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: i_rst  input  1  reset, synchronous and active-high.
REQ-004 Port: i_data  input  WIDTH  upstream word.
REQ-005 Port: i_sel  input  1  destination select (0 = channel A, 1 = channel B), sampled with i_data.
REQ-006 Port: i_valid  input  1  upstream word valid.
REQ-007 Port: o_ready  output  1  router can accept the offered word.
REQ-008 Port: o_a / o_b  output  WIDTH  channel A / B held word.
REQ-009 Port: o_a_valid / o_b_valid  output  1  channel A / B word valid.
REQ-010 Port: i_a_ready / i_b_ready  input  1  channel A / B downstream ready.
REQ-011 Port: o_a_count / o_b_count  output  8  completed transfers per channel (see Configuration).

Function
- REQ-012 Each channel SHALL hold one word and have two states: EMPTY (valid=0) and FULL (valid=1); o_x_valid SHALL be high exactly in FULL.
- REQ-013 Upstream transfer SHALL occur on a cycle with i_valid=1 and o_ready=1; downstream transfer on channel x SHALL occur on a cycle with o_x_valid=1 and i_x_ready=1.
- REQ-014 o_ready SHALL be combinational: high when the channel selected by i_sel is EMPTY, or FULL with its i_x_ready=1; o_ready SHALL NOT depend on i_valid.
- REQ-015 On upstream transfer, the selected channel SHALL load i_data and be FULL on the next cycle (latency 1 cycle, input to o_x_valid).
- REQ-016 Transitions: EMPTY->FULL on load; FULL->EMPTY on downstream transfer with no load; FULL->FULL with new data when load and downstream transfer coincide; otherwise hold.
- REQ-017 The unselected channel SHALL be unaffected by an upstream transfer.
- REQ-018 While FULL and not transferred, o_x SHALL remain stable.
- REQ-019 In EMPTY, o_x SHALL retain its last loaded value.
- REQ-020 Both channels SHALL drain independently in the same cycle; one channel stalling SHALL NOT block a word destined for the other.
- REQ-021 Sustained throughput SHALL be one word per cycle when the selected downstream is ready every cycle.
- REQ-022 A word offered while o_ready=0 SHALL NOT be loaded or lost; upstream holds it.

Reset
- REQ-023 While i_rst=1 at a rising edge: both channels EMPTY; o_a, o_b = 0; o_a_count, o_b_count = 0.
- REQ-024 Reset mid-operation SHALL discard held words without completing any transfer; no count increment on that edge.
- REQ-025 o_ready during reset SHALL follow REQ-014 using the post-reset EMPTY state from the following cycle; no load SHALL occur on a reset edge.

Configuration
- REQ-026 Macro DMUX16_ROUTER_COUNT_EN defined: o_x_count SHALL increment by 1 on each downstream transfer on channel x, wrapping 255->0.
- REQ-027 Macro undefined: counter logic SHALL be omitted and o_a_count, o_b_count SHALL be constant 0; all other behaviour identical.

Verification
- REQ-028 Reset, then i_data=16'h1234, i_sel=0, i_valid=1 one cycle, i_a_ready=1 -> next cycle o_a=16'h1234, o_a_valid=1; following cycle o_a_valid=0; o_b_valid stays 0.
- REQ-029 i_b_ready=0, send 16'hBEEF to B, then offer 16'h0001 to B -> o_ready=0, o_b holds 16'hBEEF; raise i_b_ready -> 16'h0001 loads in same cycle as BEEF drains, o_b_valid stays 1.
- REQ-030 B stalled FULL, send 16'hA5A5 to A -> o_ready=1, A delivers 16'hA5A5 one cycle later; B unchanged.
- REQ-031 Both ready, alternate i_sel every cycle for 20 words -> one word accepted per cycle, order preserved per channel.
- REQ-032 With DMUX16_ROUTER_COUNT_EN, 257 transfers on A -> o_a_count=1, o_b_count=0; without macro both read 0.
- REQ-033 Assert i_rst with both channels FULL -> next cycle both valids 0, outputs 16'h0000, counts 0.
